// File: rtl/ball_motion.sv
// Ball position/direction engine: tracks the paddle while idle, moves one pixel
// per axis per tick, reflects off walls, paddle and bricks, and flags a lost ball.
module ball_motion #(
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PADDLE_W  = 64,
    parameter int unsigned PADDLE_Y  = 440
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    input  logic       bounce_x,
    input  logic       bounce_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       moving,
    output logic       lost
);

    localparam int unsigned PW = 10;
    localparam int unsigned CW = 11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_LOST = 2'd2;

    localparam logic [PW-1:0] START_Y = PW'(PADDLE_Y - BALL_SIZE);
    localparam logic [PW-1:0] RESET_X = PW'(H_RES / 2 - BALL_SIZE / 2);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ball_x_q, ball_x_d;
    logic [PW-1:0] ball_y_q, ball_y_d;
    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;
    logic          pend_x_q, pend_x_d;
    logic          pend_y_q, pend_y_d;
    logic          moving_q, moving_d;
    logic          lost_q, lost_d;

    logic          ex, ey, fall_out;
    logic [CW-1:0] x_right, y_bottom, pad_left, pad_right;

    // Edge arithmetic is widened so right/bottom edges never wrap.
    assign x_right   = CW'(ball_x_q) + CW'(BALL_SIZE);
    assign y_bottom  = CW'(ball_y_q) + CW'(BALL_SIZE);
    assign pad_left  = CW'(paddle_x);
    assign pad_right = CW'(paddle_x) + CW'(PADDLE_W);

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        ex       = dir_x_q;
        ey       = dir_y_q;
        fall_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                ball_x_d = PW'(pad_left + CW'(PADDLE_W / 2) - CW'(BALL_SIZE / 2));
                ball_y_d = START_Y;
                dir_x_d  = 1'b1;
                dir_y_d  = 1'b0;
                pend_x_d = 1'b0;
                pend_y_d = 1'b0;
                if (launch) begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                pend_x_d = pend_x_q | bounce_x;
                pend_y_d = pend_y_q | bounce_y;
                if (tick) begin
                    // Strobes arriving with the tick are folded into this move.
                    pend_x_d = 1'b0;
                    pend_y_d = 1'b0;
                    ex = dir_x_q ^ (pend_x_q | bounce_x);
                    ey = dir_y_q ^ (pend_y_q | bounce_y);
                    if (ex && x_right >= CW'(H_RES)) begin
                        ex = 1'b0;
                    end else if (!ex && ball_x_q == '0) begin
                        ex = 1'b1;
                    end
                    if (!ey && ball_y_q == '0) begin
                        ey = 1'b1;
                    end else if (ey && y_bottom == CW'(PADDLE_Y) &&
                                 x_right > pad_left && CW'(ball_x_q) < pad_right) begin
                        ey = 1'b0;
                    end else if (ey && y_bottom >= CW'(V_RES)) begin
                        fall_out = 1'b1;
                    end
                    if (fall_out) begin
                        state_d = S_LOST;
                    end else begin
                        ball_x_d = ex ? ball_x_q + PW'(1) : ball_x_q - PW'(1);
                        ball_y_d = ey ? ball_y_q + PW'(1) : ball_y_q - PW'(1);
                        dir_x_d  = ex;
                        dir_y_d  = ey;
                    end
                end
            end
            S_LOST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        moving_d = (state_d == S_MOVE);
        lost_d   = (state_d == S_LOST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ball_x_q <= RESET_X;
            ball_y_q <= START_Y;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b0;
            pend_x_q <= 1'b0;
            pend_y_q <= 1'b0;
            moving_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            moving_q <= moving_d;
            lost_q   <= lost_d;
        end
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;
    assign dir_x  = dir_x_q;
    assign dir_y  = dir_y_q;
    assign moving = moving_q;
    assign lost   = lost_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: expected output vectors are queued as
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_ball_motion;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       launch = 1'b0;
    logic [9:0] paddle_x = 10'd100;
    logic       bounce_x = 1'b0;
    logic       bounce_y = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, moving, lost;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] sb_q[$];

    ball_motion dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .launch   (launch),
        .paddle_x (paddle_x),
        .bounce_x (bounce_x),
        .bounce_y (bounce_y),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .dir_x    (dir_x),
        .dir_y    (dir_y),
        .moving   (moving),
        .lost     (lost)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [23:0] obs();
        return {ball_x, ball_y, dir_x, dir_y, moving, lost};
    endfunction

    function automatic logic [23:0] pack(input int x, input int y, input bit dx,
                                         input bit dy, input bit mv, input bit ls);
        return {10'(x), 10'(y), dx, dy, mv, ls};
    endfunction

    function automatic string fmt(input logic [23:0] v);
        return $sformatf("x=%0d y=%0d dir=%b%b moving=%b lost=%b",
                         v[23:14], v[13:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic test_reset();
        logic [23:0] got, e;
        reset = 1'b1; paddle_x = 10'd100; tick = 1'b0; launch = 1'b0;
        step();
        sb_q.push_back(pack(316, 432, 1, 0, 0, 0));
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset: got %s, expected %s", fmt(got), fmt(e));
        end
        reset = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(pack(128, 432, 1, 0, 0, 0));
            step();
            got = obs(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL idle_track[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
        tick = 1'b0;
    endtask

    // Long run from launch at paddle 288; paddle moved to pad before the descent.
    task automatic test_sweep(input int pad, input bit lost_run);
        logic [23:0] got, e, ck;
        bit ck_valid, ex, ey, lst, mdx, mdy, done;
        int mx, my, pv;
        paddle_x = 10'd288; launch = 1'b0;
        step();
        launch = 1'b1;
        sb_q.push_back(pack(316, 432, 1, 0, 1, 0));
        step();
        launch = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL launch: got %s, expected %s", fmt(got), fmt(e));
        end
        mx = 316; my = 432; mdx = 1'b1; mdy = 1'b0; done = 1'b0;
        for (int t = 1; t <= 1000 && !done; t++) begin
            if (t == 434) paddle_x = 10'(pad);
            pv = int'(paddle_x);
            ex = mdx; ey = mdy; lst = 1'b0;
            if (ex && mx + 8 >= 640) ex = 1'b0;
            else if (!ex && mx == 0) ex = 1'b1;
            if (!ey && my == 0) ey = 1'b1;
            else if (ey && my + 8 == 440 && mx + 8 > pv && mx < pv + 64) ey = 1'b0;
            else if (ey && my + 8 >= 480) lst = 1'b1;
            if (lst) begin
                sb_q.push_back(pack(mx, my, mdx, mdy, 0, 1));
                done = 1'b1;
            end else begin
                mx = ex ? mx + 1 : mx - 1;
                my = ey ? my + 1 : my - 1;
                mdx = ex; mdy = ey;
                sb_q.push_back(pack(mx, my, mdx, mdy, 1, 0));
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            got = obs(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL sweep tick %0d: got %s, expected %s", t, fmt(got), fmt(e));
            end
            ck_valid = 1'b1;
            case (t)
                1:   ck = pack(317, 431, 1, 0, 1, 0);
                316: ck = pack(632, 116, 1, 0, 1, 0);
                317: ck = pack(631, 115, 0, 0, 1, 0);
                432: ck = pack(516, 0, 0, 0, 1, 0);
                433: ck = pack(515, 1, 0, 1, 1, 0);
                864: ck = pack(84, 432, 0, 1, 1, 0);
                865: ck = lost_run ? pack(83, 433, 0, 1, 1, 0) : pack(83, 431, 0, 0, 1, 0);
                904: ck = pack(44, 472, 0, 1, 1, 0);
                905: ck = pack(44, 472, 0, 1, 0, 1);
                default: ck_valid = 1'b0;
            endcase
            if (ck_valid) begin
                vectors++;
                if (got !== ck) begin
                    miscompares++;
                    $display("FAIL checkpoint tick %0d: got %s, expected %s", t, fmt(got), fmt(ck));
                end
            end
            if (!lost_run && t == 866) done = 1'b1;
        end
        if (lost_run) begin
            step();
            got = obs(); vectors++;
            if (got[1:0] !== 2'b00) begin
                miscompares++;
                $display("FAIL lost_pulse_end: got moving/lost=%b, expected 00", got[1:0]);
            end
            sb_q.push_back(pack(428, 432, 1, 0, 0, 0));
            step();
            got = obs(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL snap_to_paddle: got %s, expected %s", fmt(got), fmt(e));
            end
        end else begin
            reset = 1'b1;
            step();
            reset = 1'b0;
        end
    endtask

    task automatic test_bounce();
        logic [23:0] got, e;
        paddle_x = 10'd288;
        step();
        launch = 1'b1; tick = 1'b1;
        sb_q.push_back(pack(316, 432, 1, 0, 1, 0));
        step();
        launch = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL launch_tick_ignored: got %s, expected %s", fmt(got), fmt(e));
        end
        repeat (10) step();
        tick = 1'b0;
        sb_q.push_back(pack(326, 422, 1, 0, 1, 0));
        sb_q.push_back(pack(326, 422, 1, 0, 1, 0));
        sb_q.push_back(pack(327, 423, 1, 1, 1, 0));
        sb_q.push_back(pack(326, 424, 0, 1, 1, 0));
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL ten_ticks: got %s, expected %s", fmt(got), fmt(e));
        end
        bounce_y = 1'b1;
        step();
        bounce_y = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL bounce_pending: got %s, expected %s", fmt(got), fmt(e));
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL bounce_y_applied: got %s, expected %s", fmt(got), fmt(e));
        end
        bounce_x = 1'b1; tick = 1'b1;
        step();
        bounce_x = 1'b0; tick = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL bounce_x_with_tick: got %s, expected %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_reset_mid_move();
        logic [23:0] got, e;
        bounce_x = 1'b1;
        step();
        bounce_x = 1'b0;
        reset = 1'b1;
        sb_q.push_back(pack(316, 432, 1, 0, 0, 0));
        step();
        reset = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_mid_move: got %s, expected %s", fmt(got), fmt(e));
        end
        paddle_x = 10'd288;
        step();
        launch = 1'b1;
        step();
        launch = 1'b0; tick = 1'b1;
        sb_q.push_back(pack(317, 431, 1, 0, 1, 0));
        step();
        tick = 1'b0;
        got = obs(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL pending_discarded: got %s, expected %s", fmt(got), fmt(e));
        end
    endtask

    initial begin
        test_reset();
        test_sweep(60, 1'b0);
        test_sweep(400, 1'b1);
        test_bounce();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball position and direction engine for the Breakout game. It consumes the one-cycle movement strobe produced by the ball timer and advances the ball one pixel per axis per strobe. It reflects the ball off the screen walls, the paddle and bricks, and reports a lost ball. Its position outputs feed the renderer and the brick-collision logic.

## Interface
Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- BALL_SIZE, 8, ball side length in pixels (square ball)
- PADDLE_W, 64, paddle width in pixels
- PADDLE_Y, 440, y of paddle top edge; START_Y = PADDLE_Y - BALL_SIZE (432)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle movement strobe from ball timer
- launch  in  1  player launch request, level or pulse
- paddle_x  in  10  paddle left edge; the driver guarantees ≤ H_RES-PADDLE_W
- bounce_x  in  1  one-cycle strobe: brick side hit, reverse horizontal
- bounce_y  in  1  one-cycle strobe: brick top/bottom hit, reverse vertical
- ball_x  out  10  ball left edge, registered
- ball_y  out  10  ball top edge, registered
- dir_x  out  1  1 = right, 0 = left
- dir_y  out  1  1 = down, 0 = up
- moving  out  1  high in MOVE state
- lost  out  1  one-cycle pulse when ball exits bottom

## Operation
- States: IDLE, MOVE, LOST. Reset → IDLE.
- Reset values: ball_x=H_RES/2-BALL_SIZE/2 (316), ball_y=START_Y (432), dir_x=1, dir_y=0, moving=0, lost=0, pending flags cleared.
- IDLE: every cycle ball_x ← paddle_x + PADDLE_W/2 - BALL_SIZE/2, ball_y ← START_Y, dir_x←1, dir_y←0; tick, bounce_x and bounce_y are ignored; launch → MOVE.
- MOVE: bounce_x/bounce_y set sticky pend_x/pend_y; applied and cleared at next tick. A bounce strobe in the same cycle as a tick is applied at that tick.
- On a tick in MOVE, in order:
  - ex = dir_x ^ pend_x, ey = dir_y ^ pend_y.
  - Horizontal: if ex=1 and ball_x+BALL_SIZE ≥ H_RES, ex←0. Else if ex=0 and ball_x=0, ex←1.
  - Vertical: if ey=0 and ball_y=0, ey←1. Else if ey=1 and ball_y+BALL_SIZE=PADDLE_Y and ball_x+BALL_SIZE > paddle_x and ball_x < paddle_x+PADDLE_W, ey←0.
  - Else if ey=1 and ball_y+BALL_SIZE ≥ V_RES: go to LOST, position frozen, direction unchanged.
  - Otherwise ball_x ← ball_x ±1 per ex, ball_y ← ball_y ±1 per ey, dir ← (ex, ey).
- LOST: lost=1 for exactly this one cycle, then IDLE unconditionally; launch is ignored.
- Width rules: all edge comparisons are done in 11 bits to avoid overflow; positions never leave 0..H_RES-BALL_SIZE and 0..V_RES-BALL_SIZE.

## Timing
- All outputs are registered. A tick in cycle n produces the updated ball_x/ball_y/dir in cycle n+1.
- launch in cycle n (IDLE) → moving=1 in n+1. A tick in the same cycle n is ignored; the first move happens on the first tick after entry to MOVE.
- Paddle tracking in IDLE has one-cycle latency.
- lost is high in the cycle after the fatal tick, and IDLE resumes the cycle after that.
- reset in any state returns all outputs to reset values at the next edge; pending bounces are discarded.

## Test plan
- Reset, paddle_x=100 → cycle after reset ball=(316,432); next cycle ball_x=128, ball_y=432, moving=0. Ticks do not move the ball.
- paddle_x=288, launch, then 1 tick → moving=1, ball=(317,431), dir=(1,0).
- Continue ticks → after tick 316 ball=(632,116). Tick 317 → (631,115), dir_x=0. Tick 432 → (516,0). Tick 433 → (515,1), dir_y=1.
- Set paddle_x=60 → at tick 864 ball=(84,432) moving down; tick 865 → (83,431), dir_y=0.
- Same run with paddle_x=400 → tick 904 ball=(44,472); tick 905 → lost=1 for one cycle, then IDLE, ball snaps to paddle center (428,432).
- After launch and 10 ticks (326,422), pulse bounce_y → next tick (327,423), dir_y=1. Assert reset mid-MOVE → next cycle reset values, moving=0.
